sdram_arbiter_nrr: RTL
======================

# sdram_arbiter_nrr

Parametrised N-master arbiter between bus masters and the single-port `sdram_controller`. It is the successor to the fixed four-master arbiter and adds:
- a configurable master count;
- two-level priority (a high-priority class plus round-robin within each class);
- optional anti-starvation ageing.

Masters present one request at a time. The block forwards the winning request with a master tag, returns the ack, and demultiplexes tagged read data back to the owner.

## Interface
- `NUM_MASTERS`, default 4: number of masters, 2..7.
- `HIPRI_MASK`, default 4'b0001: bit i set puts master i in the high-priority class (e.g. VGA).
- `MAX_WAIT`, default 255: ageing threshold in cycles; used only with `SDRAM_ARB_AGE_EN`.
- `clock`, input, 1: single clock.
- `reset`, input, 1: synchronous, active-high.
- `m_request`, input, [N]: per-master request; held until that master's ack.
- `m_addr`, input, [N][26]: word address.
- `m_write`, input, [N]: 1 = write.
- `m_burst`, input, [N]: 1 = burst read.
- `m_byte_enable`, input, [N][4]: write byte lanes.
- `m_wdata`, input, [N][32]: write data.
- `m_ack`, output, [N]: one-cycle accept pulse.
- `m_rdata`, output, [32]: shared read data, broadcast to all masters.
- `m_rdvalid`, output, [N]: read beat valid for master i.
- `m_complete`, output, [N]: last beat of master i's read.
- `sdram_req`, output, [TAG_W]: 0 = idle, else granted master index + 1. TAG_W = $clog2(N+1).
- `sdram_addr`, output, [26]; `sdram_write`, output, [1]; `sdram_burst`, output, [1]; `sdram_byte_enable`, output, [4]; `sdram_wdata`, output, [32]: granted master's fields.
- `sdram_ack`, input, 1: controller accepted the current command.
- `sdram_rdata`, input, 32: read data from the controller.
- `sdram_rdvalid`, input, TAG_W: tag of the current read beat; 0 = none.
- `sdram_complete`, input, 1: asserted with the final beat.

## Operation
- **FSM states:** IDLE and GRANT.
- **IDLE:**
  - If any `m_request` is set, select a winner.
    - A high-priority requester, if any, wins; ties are broken by round-robin over the high class.
    - Otherwise round-robin over the low class.
  - Register the winner's index and command fields; go to GRANT.
- **Round-robin:** a separate last-winner pointer per class. The search starts at the pointer + 1 and wraps modulo N. The pointer updates on grant.
- **GRANT:**
  - Drive `sdram_req` = index + 1 and the registered fields.
  - Hold them until `sdram_ack`. The controller may take any number of cycles.
  - On `sdram_ack`, `m_ack[index]` = 1 in the same cycle (combinational); next state is IDLE.
- **Read return is independent of the FSM:**
  - `m_rdvalid[i]` = (`sdram_rdvalid` == i+1).
  - `m_complete[i]` = `sdram_complete` & (`sdram_rdvalid` == i+1).
  - `m_rdata` = `sdram_rdata`.
  - Beats for one master may overlap a grant to another.
- **Dropped request:** a request deasserted by its master while in GRANT is still completed. Masters must not do this.
- **Reset values:** in IDLE, `sdram_req` = 0, all `m_ack` = 0, both pointers at N-1 (so master 0 is searched first), ageing counters 0. `sdram_addr`, `sdram_wdata`, `sdram_byte_enable`, `sdram_write` and `sdram_burst` are all 0.

## Timing
- **Request to controller:** `m_request` high at cycle t in IDLE gives `sdram_req` valid at t+1.
- **Ack to re-arbitration:** `sdram_ack` at cycle a gives `m_ack` at a; the arbiter is in IDLE at a+1 and re-arbitrates there.
- **Minimum spacing:** one grant every 2 cycles.
- **Back-to-back requests:** a master keeping `m_request` high after its ack is treated as a new request at a+1.
- **Read path:** `m_rdvalid`, `m_complete` and `m_rdata` have zero-cycle latency from the controller inputs.
- **Reset during GRANT:** back in IDLE the next cycle, with no ack issued. The controller shares the same reset, so in-flight data is discarded.
- **Illegal tags:** `sdram_rdvalid` > N asserts no `m_rdvalid`.

## Configuration
- **`SDRAM_ARB_AGE_EN` defined:**
  - Each low-priority master has a counter $clog2(MAX_WAIT+1) wide.
  - The counter increments each cycle it requests without grant and saturates at MAX_WAIT.
  - At MAX_WAIT the master joins the high class for arbitration.
  - The counter clears on grant or on dropping its request.
- **Undefined:** pure two-level priority; a busy high-priority class may starve the low class indefinitely.

## Structure
- **Package `sdram_arb_pkg`:** `SDRAM_ADDR_W`=26, `SDRAM_DATA_W`=32, `SDRAM_BE_W`=4, the `arb_state_t` enum {IDLE, GRANT}, and a function `tag_width(n)`.
- **Sub-module `rr_pick`:** parameter N; inputs are a request vector and a pointer; outputs are a found flag and an index. It is instantiated twice, once per class.

## Test plan
- **Single master:** master 2 requests a write (addr 0x000123, data 0xDEADBEEF, be 4'b0011), controller acks 3 cycles later → `sdram_req`=3 from t+1 with fields matching, `m_ack[2]` pulses at t+4 only.
- **Round-robin:** masters 1, 2 and 3 (low class) hold requests continuously with ack after 1 cycle → grant order 1, 2, 3, 1, 2, 3, a grant every 2 cycles.
- **Priority:** masters 0 (high) and 1 request together → master 0 is granted first. With master 0 requesting continuously and ageing off, master 1 is never granted over 1000 cycles.
- **Ageing (`SDRAM_ARB_AGE_EN`, MAX_WAIT=8):** same stimulus as the priority test → master 1 is granted within 8 + 2 cycles of first requesting, then master 0 again.
- **Read demux:** burst for master 3, controller returns 8 beats with `sdram_rdvalid`=4 and `sdram_complete` on beat 8, during a grant to master 1 → `m_rdvalid[3]` high for 8 cycles, `m_complete[3]` on the last beat, no other `m_rdvalid` high, master 1 still acked.
- **Reset mid-grant:** `reset` asserted in GRANT before ack → next cycle `sdram_req`=0, no `m_ack`; after release, the first grant goes to master 0 if it is requesting.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared widths, FSM state type and tag sizing for the SDRAM arbiter.
// Revision : 1.0
// ============================================================================
package sdram_arb_pkg;

   localparam int SDRAM_ADDR_W = 26;
   localparam int SDRAM_DATA_W = 32;
   localparam int SDRAM_BE_W   = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Tag 0 means "no master", so N masters need room for N+1 codes.
   function automatic int tag_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Round-robin picker; searches from ptr+1 upward, wrapping modulo N.
// Revision : 1.0
// ============================================================================
module rr_pick #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W-1:0] w_cand;

   // Walk the offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      found  = 1'b0;
      idx    = '0;
      w_cand = '0;
      for (int k = N; k >= 1; k--) begin
         w_cand = IDX_W'((int'(ptr) + k) % N);
         if (req[w_cand]) begin
            found = 1'b1;
            idx   = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter_nrr.sv
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter_nrr
// Brief    : N-master SDRAM arbiter, two priority classes with per-class
//            round-robin; optional ageing enabled by SDRAM_ARB_AGE_EN.
// Revision : 1.0
// ============================================================================
module sdram_arbiter_nrr
   import sdram_arb_pkg::*;
#(
   parameter int                     NUM_MASTERS = 4,
   parameter logic [NUM_MASTERS-1:0] HIPRI_MASK  = {{(NUM_MASTERS-1){1'b0}}, 1'b1},
   parameter int                     MAX_WAIT    = 255,
   localparam int                    TAG_W       = tag_width(NUM_MASTERS)
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic [NUM_MASTERS-1:0]                    m_request,
   input  logic [NUM_MASTERS-1:0][SDRAM_ADDR_W-1:0]  m_addr,
   input  logic [NUM_MASTERS-1:0]                    m_write,
   input  logic [NUM_MASTERS-1:0]                    m_burst,
   input  logic [NUM_MASTERS-1:0][SDRAM_BE_W-1:0]    m_byte_enable,
   input  logic [NUM_MASTERS-1:0][SDRAM_DATA_W-1:0]  m_wdata,
   output logic [NUM_MASTERS-1:0]                    m_ack,
   output logic [SDRAM_DATA_W-1:0]                   m_rdata,
   output logic [NUM_MASTERS-1:0]                    m_rdvalid,
   output logic [NUM_MASTERS-1:0]                    m_complete,
   output logic [TAG_W-1:0]                          sdram_req,
   output logic [SDRAM_ADDR_W-1:0]                   sdram_addr,
   output logic                                      sdram_write,
   output logic                                      sdram_burst,
   output logic [SDRAM_BE_W-1:0]                     sdram_byte_enable,
   output logic [SDRAM_DATA_W-1:0]                   sdram_wdata,
   input  logic                                      sdram_ack,
   input  logic [SDRAM_DATA_W-1:0]                   sdram_rdata,
   input  logic [TAG_W-1:0]                          sdram_rdvalid,
   input  logic                                      sdram_complete
);

   localparam int               c_idx_w    = $clog2(NUM_MASTERS);
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_MASTERS - 1);

   arb_state_t r_state;
   arb_state_t w_state_nxt;

   logic [c_idx_w-1:0]      r_idx;
   logic [c_idx_w-1:0]      r_hi_ptr;
   logic [c_idx_w-1:0]      r_lo_ptr;
   logic [SDRAM_ADDR_W-1:0] r_addr;
   logic                    r_write;
   logic                    r_burst;
   logic [SDRAM_BE_W-1:0]   r_be;
   logic [SDRAM_DATA_W-1:0] r_wdata;

   logic [NUM_MASTERS-1:0]  w_aged;
   logic [NUM_MASTERS-1:0]  w_hi_class;
   logic [NUM_MASTERS-1:0]  w_hi_req;
   logic [NUM_MASTERS-1:0]  w_lo_req;
   logic                    w_hi_found;
   logic                    w_lo_found;
   logic [c_idx_w-1:0]      w_hi_idx;
   logic [c_idx_w-1:0]      w_lo_idx;
   logic [c_idx_w-1:0]      w_win_idx;
   logic                    w_grant;

`ifdef SDRAM_ARB_AGE_EN
   localparam int                 c_age_w    = $clog2(MAX_WAIT + 1);
   localparam logic [c_age_w-1:0] c_max_wait = c_age_w'(MAX_WAIT);

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_age
      if (HIPRI_MASK[i]) begin : g_hi
         assign w_aged[i] = 1'b0;
      end else begin : g_lo
         logic [c_age_w-1:0] r_age;
         logic               w_served;

         // Cleared both at selection and while its own command is in flight.
         assign w_served = (w_grant && (w_win_idx == c_idx_w'(i))) ||
                           ((r_state == GRANT) && (r_idx == c_idx_w'(i)));

         always_ff @(posedge clock) begin
            if (reset || !m_request[i] || w_served) begin
               r_age <= '0;
            end else if (r_age != c_max_wait) begin
               r_age <= r_age + 1'b1;
            end
         end

         assign w_aged[i] = (r_age == c_max_wait);
      end
   end
`else
   assign w_aged = '0;
`endif

   assign w_hi_class = HIPRI_MASK | w_aged;
   assign w_hi_req   = m_request & w_hi_class;
   assign w_lo_req   = m_request & ~w_hi_class;

   rr_pick #(.N(NUM_MASTERS), .IDX_W(c_idx_w)) u_pick_hi (
      .req   (w_hi_req),
      .ptr   (r_hi_ptr),
      .found (w_hi_found),
      .idx   (w_hi_idx)
   );

   rr_pick #(.N(NUM_MASTERS), .IDX_W(c_idx_w)) u_pick_lo (
      .req   (w_lo_req),
      .ptr   (r_lo_ptr),
      .found (w_lo_found),
      .idx   (w_lo_idx)
   );

   assign w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
   assign w_grant   = (r_state == IDLE) && (w_hi_found || w_lo_found);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Ack is suppressed under reset so an interrupted grant never completes.
   always_comb begin
      w_state_nxt = r_state;
      m_ack       = '0;
      case (r_state)
         IDLE: begin
            if (w_grant) begin
               w_state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (sdram_ack) begin
               w_state_nxt = IDLE;
               if (!reset) begin
                  m_ack[r_idx] = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_idx    <= '0;
         r_hi_ptr <= c_last_idx;
         r_lo_ptr <= c_last_idx;
         r_addr   <= '0;
         r_write  <= 1'b0;
         r_burst  <= 1'b0;
         r_be     <= '0;
         r_wdata  <= '0;
      end else if (w_grant) begin
         r_idx   <= w_win_idx;
         r_addr  <= m_addr[w_win_idx];
         r_write <= m_write[w_win_idx];
         r_burst <= m_burst[w_win_idx];
         r_be    <= m_byte_enable[w_win_idx];
         r_wdata <= m_wdata[w_win_idx];
         if (w_hi_found) begin
            r_hi_ptr <= w_hi_idx;
         end else begin
            r_lo_ptr <= w_lo_idx;
         end
      end
   end

   assign sdram_req         = (r_state == GRANT) ? (TAG_W'(r_idx) + TAG_W'(1)) : '0;
   assign sdram_addr        = r_addr;
   assign sdram_write       = r_write;
   assign sdram_burst       = r_burst;
   assign sdram_byte_enable = r_be;
   assign sdram_wdata       = r_wdata;

   assign m_rdata = sdram_rdata;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_rd_demux
      assign m_rdvalid[i]  = (sdram_rdvalid == TAG_W'(i + 1));
      assign m_complete[i] = sdram_complete && (sdram_rdvalid == TAG_W'(i + 1));
   end

endmodule
`default_nettype wire
